// File: rtl/reg_file_dump_reader.sv
// Walks a programmed register range through the register-file read port and
// streams each register's contents with its index over a valid/ready interface.
module reg_file_dump_reader #(
  parameter int unsigned N      = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [N-1:0]      rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              out_valid_q, out_valid_d;
  logic [N-1:0]      out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_index_q, out_index_d;
  logic              out_last_q, out_last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    last_d      = last_q;
    rd_addr_d   = rd_addr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (first_reg <= last_reg) begin
            last_d    = last_reg;
            ptr_d     = first_reg;
            rd_addr_d = first_reg;
            state_d   = FETCH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FETCH: begin
        out_data_d  = rd_data;
        out_index_d = ptr_q;
        out_last_d  = (ptr_q == last_q);
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          // Stopping on out_last keeps ptr from ever stepping past last_q,
          // so a range ending at the top register cannot wrap.
          if (out_last_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ptr_d     = ptr_q + 1'b1;
            rd_addr_d = ptr_q + 1'b1;
            state_d   = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides any handshake completing in the same cycle.
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      last_q      <= '0;
      rd_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      last_q      <= last_d;
      rd_addr_q   <= rd_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign rd_addr   = rd_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_reg_file_dump_reader.sv
// Bench for reg_file_dump_reader: table of dump ranges, randomized dumps
// against a register-array model, and abort / mid-dump reset sequences.
module tb_reg_file_dump_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  first_reg = '0;
  logic [4:0]  last_reg = '0;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_index;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err;

  logic [31:0] regs [32];
  assign rd_data = regs[rd_addr];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_dump_reader #(.N(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .first_reg(first_reg), .last_reg(last_reg),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .busy(busy), .done(done), .err(err)
  );

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // mode 0: ready always high, 1: one cycle on / three off, 2: random.
  // inj >= 0: when that index is accepted, pulse start and write reg 25.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int mode,
                          input int inj, output int nwords);
    int  exp_idx, n, done_at, first_valid_n;
    bit  exp_err, finished, stalled;
    logic [31:0] hold_data;
    logic [4:0]  hold_idx;
    logic [31:0] exp_data;
    exp_err = (f > l);
    exp_idx = int'(f);
    nwords = 0; n = 0; done_at = -1; first_valid_n = -1;
    finished = 0; stalled = 0; hold_data = '0; hold_idx = '0;
    @(negedge clk);
    start = 1'b1; first_reg = f; last_reg = l; out_ready = 1'b0;
    while (!finished && n < 400) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      first_reg = 5'($urandom);
      last_reg = 5'($urandom);
      if (exp_err) begin
        check("err_pulse", {63'd0, err}, (n == 1) ? 64'd1 : 64'd0);
        check("err_busy", {63'd0, busy}, 64'd0);
        check("err_no_valid", {63'd0, out_valid}, 64'd0);
        check("err_no_done", {63'd0, done}, 64'd0);
        if (n == 3) finished = 1;
        continue;
      end
      check("done", {63'd0, done}, (n == done_at) ? 64'd1 : 64'd0);
      check("no_err", {63'd0, err}, 64'd0);
      if (n == done_at) begin
        check("busy_after_done", {63'd0, busy}, 64'd0);
        check("valid_after_done", {63'd0, out_valid}, 64'd0);
        finished = 1;
        continue;
      end
      check("busy", {63'd0, busy}, 64'd1);
      if (out_valid) begin
        if (first_valid_n < 0) first_valid_n = n;
        if (stalled) begin
          check("stall_data", {32'd0, out_data}, {32'd0, hold_data});
          check("stall_index", {59'd0, out_index}, {59'd0, hold_idx});
        end
        case (mode)
          0: out_ready = 1'b1;
          1: out_ready = (n % 4 == 0);
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (out_ready) begin
          exp_data = (exp_idx <= 31) ? regs[exp_idx] : 32'd0;
          check("index", {59'd0, out_index}, 64'(exp_idx));
          check("data", {32'd0, out_data}, {32'd0, exp_data});
          check("last", {63'd0, out_last}, (exp_idx == int'(l)) ? 64'd1 : 64'd0);
          nwords++;
          if (exp_idx == int'(l)) done_at = n + 1;
          if (exp_idx == inj) begin
            start = 1'b1; first_reg = 5'd5; last_reg = 5'd31;
            regs[25] = 32'h12345678;
          end
          exp_idx++;
          stalled = 0;
        end else begin
          stalled = 1; hold_data = out_data; hold_idx = out_index;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        stalled = 0;
      end
    end
    if (!finished) check("timeout", 64'd0, 64'd1);
    if (!exp_err) check("first_valid_latency", 64'(first_valid_n), 64'd2);
    if (!exp_err && mode == 0) check("throughput_done_cycle", 64'(done_at), 64'(2 * nwords + 1));
    out_ready = 1'b0;
  endtask

  // Runs a 0..31 dump until index 8 is presented, then stalls there.
  task automatic reach_word8(output bit ok);
    int n;
    ok = 0;
    @(negedge clk);
    start = 1'b1; first_reg = 5'd0; last_reg = 5'd31; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (n = 0; n < 100 && !ok; n++) begin
      if (out_valid && out_index == 5'd8) begin
        out_ready = 1'b0; ok = 1;
      end else begin
        @(negedge clk);
      end
    end
    check("reach_word8", {63'd0, ok}, 64'd1);
  endtask

  typedef struct {
    logic [4:0] f;
    logic [4:0] l;
    int         mode;
    int         inj;
    int         exp_words;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int  nw;
    bit  ok;
    for (int k = 0; k < 32; k++) regs[k] = 32'hA500_0000 + 32'(k);

    vecs[0] = '{5'd0,  5'd31, 0, -1, 32};
    vecs[1] = '{5'd4,  5'd7,  1, -1, 4};
    vecs[2] = '{5'd13, 5'd13, 0, -1, 1};
    vecs[3] = '{5'd20, 5'd3,  0, -1, 0};
    vecs[4] = '{5'd30, 5'd31, 2, -1, 2};
    vecs[5] = '{5'd0,  5'd31, 0, 10, 32};

    #2;
    check("rst_rd_addr", {59'd0, rd_addr}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check("rst_busy_done_err", {61'd0, busy, done, err}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      if (i == 2) regs[13] = 32'hDEADBEEF;
      run_dump(vecs[i].f, vecs[i].l, vecs[i].mode, vecs[i].inj, nw);
      check("word_count", 64'(nw), 64'(vecs[i].exp_words));
    end
    check("reg25_written", {32'd0, regs[25]}, 64'h12345678);

    // Abort while stalled on word 8.
    reach_word8(ok);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_valid", {63'd0, out_valid}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_err", {63'd0, err}, 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_quiet", {61'd0, out_valid, done, busy}, 64'd0);
    end
    run_dump(5'd4, 5'd7, 0, -1, nw);
    check("abort_recover_count", 64'(nw), 64'd4);

    // Asynchronous reset while stalled on word 8.
    reach_word8(ok);
    #2 reset = 1'b0;
    #1;
    check("rstmid_rd_addr", {59'd0, rd_addr}, 64'd0);
    check("rstmid_out", {27'd0, out_data, out_index}, 64'd0);
    check("rstmid_flags", {59'd0, out_valid, out_last, busy, done, err}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    check("rstmid_no_done", {63'd0, done}, 64'd0);
    run_dump(5'd4, 5'd7, 1, -1, nw);
    check("rst_recover_count", 64'(nw), 64'd4);

    // Randomized ranges and register contents.
    for (int t = 0; t < 20; t++) begin
      logic [4:0] f, l, tmp;
      for (int k = 0; k < 32; k++) regs[k] = $urandom;
      f = 5'($urandom); l = 5'($urandom);
      if (f > l && $urandom_range(0, 3) != 0) begin tmp = f; f = l; l = tmp; end
      run_dump(f, l, 2, -1, nw);
      check("rand_word_count", 64'(nw), (f > l) ? 64'd0 : 64'(int'(l) - int'(f) + 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
